// File: rtl/arb_mux.sv
// N-input valid/ready data selector with one registered output stage; fixed or round-robin grant.
// Optional transfer counter (CNT_CLR / XFER_CNT) enabled by defining ARB_MUX_STATS_EN.
module arb_mux #(
   parameter int WIDTH = 8,
   parameter int N_IN  = 4,
   parameter int SEL_W = $clog2(N_IN)
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  MODE,
   input  logic [SEL_W-1:0]      MUX_SEL,
   input  logic [N_IN*WIDTH-1:0] IN_DATA,
   input  logic [N_IN-1:0]       IN_VALID,
   output logic [N_IN-1:0]       IN_READY,
   output logic [WIDTH-1:0]      OUT_DATA,
   output logic [SEL_W-1:0]      OUT_CH,
   output logic                  OUT_VALID,
   input  logic                  OUT_READY
`ifdef ARB_MUX_STATS_EN
   ,
   input  logic                  CNT_CLR,
   output logic [15:0]           XFER_CNT
`endif
);

   logic [SEL_W-1:0] last_q;
   logic [SEL_W-1:0] gnt;
   logic [SEL_W-1:0] cand;
   logic             gnt_vld;
   logic             acc;
   logic             xfer;
   logic [WIDTH-1:0] sel_data;
   int unsigned      rr_idx;

   assign acc = !OUT_VALID || OUT_READY;

   always_comb begin
      gnt     = '0;
      gnt_vld = 1'b0;
      cand    = '0;
      rr_idx  = 0;
      if (!MODE) begin
         // Out-of-range select (non-power-of-2 N_IN) falls back to channel 0
         if (32'(MUX_SEL) < N_IN) gnt = MUX_SEL;
         gnt_vld = IN_VALID[gnt];
      end else begin
         for (int unsigned k = 1; k <= N_IN; k++) begin
            rr_idx = 32'(last_q) + k;
            if (rr_idx >= N_IN) rr_idx = rr_idx - N_IN;
            cand = SEL_W'(rr_idx);
            if (!gnt_vld && IN_VALID[cand]) begin
               gnt_vld = 1'b1;
               gnt     = cand;
            end
         end
      end
   end

   assign xfer     = !RST && acc && gnt_vld;
   assign sel_data = IN_DATA[32'(gnt)*WIDTH +: WIDTH];

   always_comb begin
      IN_READY = '0;
      if (xfer) IN_READY[gnt] = 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         OUT_DATA  <= '0;
         OUT_CH    <= '0;
         OUT_VALID <= 1'b0;
         last_q    <= SEL_W'(N_IN - 1);
      end else if (acc) begin
         if (xfer) begin
            OUT_DATA  <= sel_data;
            OUT_CH    <= gnt;
            OUT_VALID <= 1'b1;
            if (MODE) last_q <= gnt;
         end else begin
            OUT_VALID <= 1'b0;
         end
      end
   end

`ifdef ARB_MUX_STATS_EN
   always_ff @(posedge CLK) begin
      if (RST || CNT_CLR) begin
         XFER_CNT <= '0;
      end else if (OUT_VALID && OUT_READY && (XFER_CNT != '1)) begin
         XFER_CNT <= XFER_CNT + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: per-cycle comparison against a behavioural model plus literal spot checks.
// Define ARB_MUX_STATS_EN for both files to exercise the transfer counter.
module tb_arb_mux;

   localparam int W = 8;
   localparam int N = 4;
   localparam int S = 2;

   logic           CLK = 1'b0;
   logic           RST;
   logic           MODE;
   logic [S-1:0]   MUX_SEL;
   logic [N*W-1:0] IN_DATA;
   logic [N-1:0]   IN_VALID;
   logic [N-1:0]   IN_READY;
   logic [W-1:0]   OUT_DATA;
   logic [S-1:0]   OUT_CH;
   logic           OUT_VALID;
   logic           OUT_READY;
`ifdef ARB_MUX_STATS_EN
   logic           CNT_CLR;
   logic [15:0]    XFER_CNT;
`endif

   int tests = 0;
   int fails = 0;

   arb_mux #(.WIDTH(W), .N_IN(N)) dut (
      .CLK(CLK), .RST(RST), .MODE(MODE), .MUX_SEL(MUX_SEL),
      .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .OUT_DATA(OUT_DATA), .OUT_CH(OUT_CH), .OUT_VALID(OUT_VALID),
      .OUT_READY(OUT_READY)
`ifdef ARB_MUX_STATS_EN
      , .CNT_CLR(CNT_CLR), .XFER_CNT(XFER_CNT)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: output register contents, round-robin history, counter
   bit      m_init = 0;
   bit      m_valid;
   int      m_data, m_ch, m_last, m_cnt;

   function automatic void model_grant(input logic mode, input int sel, input logic [N-1:0] v,
                                       input int last, output bit ok, output int ch);
      ok = 0;
      ch = 0;
      if (!mode) begin
         ch = (sel < N) ? sel : 0;
         ok = v[ch];
      end else begin
         for (int k = 1; k <= N; k++) begin
            int c = (last + k) % N;
            if (!ok && v[c]) begin
               ok = 1;
               ch = c;
            end
         end
      end
   endfunction

   always @(posedge CLK) begin
      bit ok;
      int ch;
      if (RST) begin
         m_valid = 0; m_data = 0; m_ch = 0; m_last = N - 1; m_cnt = 0; m_init = 1;
      end else if (m_init) begin
         model_grant(MODE, int'(MUX_SEL), IN_VALID, m_last, ok, ch);
`ifdef ARB_MUX_STATS_EN
         if (CNT_CLR) m_cnt = 0;
         else if (m_valid && OUT_READY && m_cnt < 16'hFFFF) m_cnt = m_cnt + 1;
`endif
         if (!m_valid || OUT_READY) begin
            if (ok) begin
               m_data  = int'(IN_DATA[ch*W +: W]);
               m_ch    = ch;
               m_valid = 1;
               if (MODE) m_last = ch;
            end else begin
               m_valid = 0;
            end
         end
      end
   end

   always @(negedge CLK) begin
      bit ok;
      int ch;
      logic [N-1:0] exp_rdy;
      if (m_init) begin
         model_grant(MODE, int'(MUX_SEL), IN_VALID, m_last, ok, ch);
         exp_rdy = '0;
         if (!RST && (!m_valid || OUT_READY) && ok) exp_rdy[ch] = 1'b1;
         check("in_ready", 32'(IN_READY), 32'(exp_rdy));
         check("out_valid", 32'(OUT_VALID), 32'(m_valid));
         check("out_data", 32'(OUT_DATA), m_data);
         check("out_ch", 32'(OUT_CH), m_ch);
`ifdef ARB_MUX_STATS_EN
         check("xfer_cnt", 32'(XFER_CNT), m_cnt);
`endif
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST = 1'b1; MODE = 1'b1; MUX_SEL = '0; IN_DATA = '0; IN_VALID = 4'b1111; OUT_READY = 1'b0;
`ifdef ARB_MUX_STATS_EN
      CNT_CLR = 1'b0;
`endif
      tick();
      #1 check("rst_ready", 32'(IN_READY), 32'h0);
      tick();
      check("rst_data", 32'(OUT_DATA), 32'h0);
      check("rst_ch", 32'(OUT_CH), 32'h0);
      check("rst_valid", 32'(OUT_VALID), 32'h0);

      // fixed select, ch2 valid
      RST = 1'b0; MODE = 1'b0; MUX_SEL = 2'd2; IN_DATA = 32'h00A5_0000; IN_VALID = 4'b0100; OUT_READY = 1'b1;
      #1 check("fix_ready", 32'(IN_READY), 32'h4);
      tick();
      check("fix_data", 32'(OUT_DATA), 32'hA5);
      check("fix_ch", 32'(OUT_CH), 32'h2);
      check("fix_valid", 32'(OUT_VALID), 32'h1);

      // fixed select, target idle: bubble, data held
      MUX_SEL = 2'd1; IN_VALID = 4'b1101;
      #1 check("idle_ready", 32'(IN_READY), 32'h0);
      tick();
      check("idle_valid", 32'(OUT_VALID), 32'h0);
      check("idle_hold", 32'(OUT_DATA), 32'hA5);

      // round-robin fairness, LAST still at reset value
      MODE = 1'b1; IN_VALID = 4'b1111; IN_DATA = 32'h1312_1110;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("rr_ch", 32'(OUT_CH), i % 4);
         check("rr_data", 32'(OUT_DATA), 32'h10 + i % 4);
      end

      // skip and wrap after a grant to ch3
      IN_VALID = 4'b0101;
      tick(); check("wrap0", 32'(OUT_CH), 32'h0);
      tick(); check("wrap2", 32'(OUT_CH), 32'h2);
      tick(); check("wrap0b", 32'(OUT_CH), 32'h0);

      // backpressure
      MODE = 1'b0; MUX_SEL = 2'd1; IN_DATA = 32'h4433_3C11; IN_VALID = 4'b0010;
      tick();
      check("bp_load", 32'(OUT_DATA), 32'h3C);
      OUT_READY = 1'b0; IN_VALID = 4'b1111; MUX_SEL = 2'd3;
      #1 check("bp_ready0", 32'(IN_READY), 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_data", 32'(OUT_DATA), 32'h3C);
         check("bp_valid", 32'(OUT_VALID), 32'h1);
         check("bp_ready", 32'(IN_READY), 32'h0);
      end
      OUT_READY = 1'b1;
      #1 check("bp_rel_ready", 32'(IN_READY), 32'h8);
      tick();
      check("bp_rel_data", 32'(OUT_DATA), 32'h44);
      check("bp_rel_ch", 32'(OUT_CH), 32'h3);
      check("bp_rel_valid", 32'(OUT_VALID), 32'h1);

      // LAST retained across mode switch (last RR grant was ch0)
      MODE = 1'b1;
      #1 check("keep_last_ready", 32'(IN_READY), 32'h2);
      tick();
      check("keep_last_ch", 32'(OUT_CH), 32'h1);

      // reset while a beat is pending
      RST = 1'b1;
      #1 check("midrst_ready", 32'(IN_READY), 32'h0);
      tick();
      check("midrst_valid", 32'(OUT_VALID), 32'h0);
      check("midrst_data", 32'(OUT_DATA), 32'h0);
      RST = 1'b0;
      tick();
      check("post_rst_ch", 32'(OUT_CH), 32'h0);

`ifdef ARB_MUX_STATS_EN
      RST = 1'b1;
      tick();
      RST = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      check("cnt5", 32'(XFER_CNT), 32'd5);
      CNT_CLR = 1'b1;
      tick();
      check("cnt_clr", 32'(XFER_CNT), 32'd0);
      CNT_CLR = 1'b0;
      tick();
      check("cnt_after_clr", 32'(XFER_CNT), 32'd1);
      RST = 1'b1;
      tick();
      check("cnt_rst_valid", 32'(OUT_VALID), 32'h0);
      check("cnt_rst", 32'(XFER_CNT), 32'd0);
      RST = 1'b0;
      for (int i = 0; i < 65540; i++) tick();
      check("cnt_sat", 32'(XFER_CNT), 32'hFFFF);
`endif

      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/arb_mux.md
Name: arb_mux

Overview:
- Parametrised N-input, WIDTH-bit data selector with one registered output stage and valid/ready handshaking on every input and on the output.
- Two selection modes:
  - Fixed: the source is chosen by MUX_SEL.
  - Round-robin: the block arbitrates among inputs that have valid data.
- Sits between multiple 8-bit data producers (register file, ALU result, scratch RAM, input port) and a single consumer in the MCU datapath.
- Replaces the plain combinational 4:1 selection where sources may stall.

Parameters:
- WIDTH, 8, data width of every channel.
- N_IN, 4, number of input channels (2..16).
- SEL_W, $clog2(N_IN), width of MUX_SEL and OUT_CH (derived; not overridden).

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  synchronous reset, active-high.
- MODE  input  1  0 = fixed select via MUX_SEL; 1 = round-robin.
- MUX_SEL  input  SEL_W  channel index used when MODE=0.
- IN_DATA  input  N_IN*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- IN_VALID  input  N_IN  per-channel data-valid.
- IN_READY  output  N_IN  per-channel accept; combinational.
- OUT_DATA  output  WIDTH  registered selected data.
- OUT_CH  output  SEL_W  registered index of the channel that produced OUT_DATA.
- OUT_VALID  output  1  registered output-valid.
- OUT_READY  input  1  consumer accept.

Behaviour:
- Reset (RST=1 at a clock edge):
  - OUT_DATA=0, OUT_CH=0, OUT_VALID=0.
  - Round-robin pointer LAST=N_IN-1, so channel 0 has first priority.
  - IN_READY is all-zero during any cycle RST=1.
- Reset mid-transfer: a pending OUT_VALID beat is discarded; a source whose IN_READY was high in that cycle is not considered transferred.
- Accept condition: ACC = !OUT_VALID || OUT_READY. The output register is either empty or being drained this cycle.
- Grant, MODE=0:
  - Candidate is MUX_SEL.
  - If MUX_SEL >= N_IN (non-power-of-2 N_IN), the candidate is channel 0.
  - GNT is valid only if IN_VALID[candidate]=1.
- Grant, MODE=1:
  - Search channels LAST+1, LAST+2, ... wrapping modulo N_IN.
  - GNT is the first channel with IN_VALID=1; no grant if IN_VALID is all-zero.
- IN_READY[i] = !RST && ACC && GNT valid && (GNT==i). At most one bit is high (one-hot or zero).
- Transfer on channel i: IN_VALID[i] && IN_READY[i]. On the next edge:
  - OUT_DATA <= channel i data, OUT_CH <= i, OUT_VALID <= 1.
  - If MODE=1, LAST <= i. LAST is unchanged in MODE=0.
- No transfer while ACC=1: OUT_VALID <= 0 on the next edge (bubble). OUT_DATA and OUT_CH hold their values.
- Stall (OUT_VALID=1, OUT_READY=0): OUT_DATA, OUT_CH and OUT_VALID hold; all IN_READY=0.
- Latency: 1 cycle from input handshake to OUT_VALID.
- Throughput: 1 beat/cycle with OUT_READY held high, including back-to-back beats from the same channel.
- Fairness (MODE=1): with all N_IN channels continuously valid, grants cycle 0,1,..,N_IN-1,0,...
- MODE or MUX_SEL changes take effect in the same cycle's grant. LAST is retained across MODE switches.
- IN_DATA and IN_VALID are not registered. Sources must hold data and valid until their own IN_READY=1.

Optional Feature:
- Macro: ARB_MUX_STATS_EN.
- Defined:
  - Adds port CNT_CLR (input, 1) and port XFER_CNT (output, 16).
  - XFER_CNT increments by 1 on each output transfer (OUT_VALID && OUT_READY) and saturates at 16'hFFFF.
  - CNT_CLR=1 sets it to 0 on the next edge; clear wins over a simultaneous increment.
  - RST clears XFER_CNT to 0.
- Undefined: neither port exists and no counter logic is synthesised; all other behaviour is identical.

Test Plan:
- Reset/fixed select: RST=1 for 2 cycles, then MODE=0, MUX_SEL=2, IN_DATA ch2=8'hA5, IN_VALID=4'b0100, OUT_READY=1 → IN_READY=4'b0100. Next cycle OUT_DATA=8'hA5, OUT_CH=2, OUT_VALID=1; before release, outputs were 0.
- Fixed select, target idle: MODE=0, MUX_SEL=1, IN_VALID=4'b1101 → IN_READY=0000 and OUT_VALID=0 the next cycle; ch1 is never granted while invalid.
- Round-robin fairness: MODE=1, IN_VALID=4'b1111 held, OUT_READY=1, ch i data=8'h10+i → over 8 cycles OUT_CH=0,1,2,3,0,1,2,3 and OUT_DATA=8'h10..8'h13 repeating.
- Round-robin skip and wrap: after a grant to ch3, IN_VALID=4'b0101 → next grant ch0, then ch2, then ch0.
- Backpressure: OUT_VALID=1, OUT_DATA=8'h3C, OUT_READY=0 for 3 cycles while IN_VALID=4'b1111 → OUT_DATA stays 8'h3C, IN_READY=0000. OUT_READY=1 → same-cycle IN_READY one-hot, new data the next cycle with no bubble.
- Stats and reset mid-operation (ARB_MUX_STATS_EN):
  - 5 output transfers → XFER_CNT=5.
  - CNT_CLR and a transfer in the same cycle → XFER_CNT=0.
  - RST asserted while OUT_VALID=1 → OUT_VALID=0 and XFER_CNT=0 the next cycle.
  - Preload near 16'hFFFF and transfer twice → XFER_CNT stays 16'hFFFF.
